// File: rtl/ret_addr_stack.sv
// Return-address stack feeding the program counter: CALL pushes the return address,
// RET pops it onto ret_addr with a one-cycle pc_load strobe. Sticky overflow/underflow flags.
module ret_addr_stack #(
  parameter int unsigned AW    = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     call,
  input  logic                     ret,
  input  logic [AW-1:0]            call_addr,
  input  logic                     clear_err,
  output logic [AW-1:0]            ret_addr,
  output logic                     pc_load,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned CW = IW + 1;

  logic [AW-1:0] mem_q [DEPTH];

  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] ret_addr_q, ret_addr_d;
  logic          pc_load_q, pc_load_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;

  logic [CW-1:0] cnt_m1;
  logic [IW-1:0] top_idx;
  logic [IW-1:0] wr_idx;
  logic          wr_en;
  logic          ovf_set;
  logic          unf_set;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign cnt_m1  = count_q - CW'(1);
  assign top_idx = cnt_m1[IW-1:0];
  // A simultaneous call/ret on a non-empty stack overwrites the top in place.
  assign wr_idx  = (ret && !empty) ? top_idx : count_q[IW-1:0];

  always_comb begin
    count_d    = count_q;
    ret_addr_d = ret_addr_q;
    pc_load_d  = 1'b0;
    wr_en      = 1'b0;
    ovf_set    = 1'b0;
    unf_set    = 1'b0;
    case ({call, ret})
      2'b10: begin
        if (full) begin
          ovf_set = 1'b1;
        end else begin
          wr_en   = 1'b1;
          count_d = count_q + CW'(1);
        end
      end
      2'b01: begin
        if (empty) begin
          unf_set    = 1'b1;
          ret_addr_d = '0;
        end else begin
          ret_addr_d = mem_q[top_idx];
          pc_load_d  = 1'b1;
          count_d    = cnt_m1;
        end
      end
      2'b11: begin
        wr_en = 1'b1;
        if (empty) begin
          unf_set = 1'b1;
          count_d = CW'(1);
        end else begin
          ret_addr_d = mem_q[top_idx];
          pc_load_d  = 1'b1;
        end
      end
      default: ;
    endcase
    overflow_d  = (overflow_q  & ~clear_err) | ovf_set;
    underflow_d = (underflow_q & ~clear_err) | unf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q     <= '0;
      ret_addr_q  <= '0;
      pc_load_q   <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      count_q     <= count_d;
      ret_addr_q  <= ret_addr_d;
      pc_load_q   <= pc_load_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_idx] <= call_addr;
  end

  assign count     = count_q;
  assign ret_addr  = ret_addr_q;
  assign pc_load   = pc_load_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: directed scenarios plus random call/ret/clear/reset traffic
// checked against a queue-based stack model, with a small PC register on the outputs.
module tb_ret_addr_stack;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       call, ret, clear_err;
  logic [7:0] call_addr;
  logic [7:0] ret_addr;
  logic       pc_load, full, empty, overflow, underflow;
  logic [3:0] count;
  logic [7:0] pc_q;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] stk[$];
  logic [7:0] m_ret;
  logic       m_pcl, m_ovf, m_unf;
  logic [7:0] m_pc;

  ret_addr_stack #(.AW(8), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .call(call), .ret(ret), .call_addr(call_addr),
    .clear_err(clear_err), .ret_addr(ret_addr), .pc_load(pc_load), .full(full),
    .empty(empty), .count(count), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  // Program counter consuming the stack outputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       pc_q <= 8'h00;
    else if (pc_load) pc_q <= ret_addr;
    else              pc_q <= pc_q + 8'h01;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare_all();
    check("count",     32'(count),     32'(stk.size()));
    check("full",      32'(full),      32'(stk.size() == 8));
    check("empty",     32'(empty),     32'(stk.size() == 0));
    check("pc_load",   32'(pc_load),   32'(m_pcl));
    check("ret_addr",  32'(ret_addr),  32'(m_ret));
    check("overflow",  32'(overflow),  32'(m_ovf));
    check("underflow", 32'(underflow), 32'(m_unf));
    check("pc",        32'(pc_q),      32'(m_pc));
  endtask

  task automatic model_clear();
    stk.delete();
    m_ret = 8'h00; m_pcl = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_pc = 8'h00;
  endtask

  task automatic model_edge(input logic c, input logic r, input logic [7:0] a, input logic ce);
    m_pc = m_pcl ? m_ret : m_pc + 8'h01;
    if (ce) begin m_ovf = 1'b0; m_unf = 1'b0; end
    m_pcl = 1'b0;
    if (c && r) begin
      if (stk.size() == 0) begin
        stk.push_back(a);
        m_unf = 1'b1;
      end else begin
        m_ret = stk[$];
        stk[$] = a;
        m_pcl = 1'b1;
      end
    end else if (c) begin
      if (stk.size() == 8) m_ovf = 1'b1;
      else stk.push_back(a);
    end else if (r) begin
      if (stk.size() == 0) begin
        m_ret = 8'h00;
        m_unf = 1'b1;
      end else begin
        m_ret = stk.pop_back();
        m_pcl = 1'b1;
      end
    end
  endtask

  task automatic step(input logic c, input logic r, input logic [7:0] a, input logic ce);
    call = c; ret = r; call_addr = a; clear_err = ce;
    @(posedge clk);
    model_edge(c, r, a, ce);
    #1;
    compare_all();
    call = 1'b0; ret = 1'b0; clear_err = 1'b0;
  endtask

  // Called at posedge+1: asserts reset mid-cycle, checks without any clock edge, releases.
  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 model_clear();
    compare_all();
    #2 rst_n = 1'b1;
  endtask

  initial begin
    int unsigned pc_pct;
    rst_n = 1'b0; call = 1'b0; ret = 1'b0; clear_err = 1'b0; call_addr = 8'h00;
    model_clear();
    repeat (2) @(posedge clk);
    #1 compare_all();
    rst_n = 1'b1;

    // LIFO order
    step(1, 0, 8'h10, 0); step(1, 0, 8'h20, 0); step(1, 0, 8'h30, 0);
    step(0, 1, 8'h00, 0); step(0, 1, 8'h00, 0); step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Overflow: 0x09 is discarded
    for (int i = 1; i <= 9; i++) step(1, 0, 8'(i), 0);
    for (int i = 0; i < 8; i++) step(0, 1, 8'h00, 0);

    // Underflow then clear; clear with a new error in the same cycle keeps the flag
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 1);
    step(0, 1, 8'h00, 1);
    step(0, 0, 8'h00, 1);

    // Simultaneous call/ret, including when full and when empty
    step(1, 0, 8'hA0, 0);
    step(1, 1, 8'hB0, 0);
    step(0, 1, 8'h00, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 8'(8'hC0 + i), 0);
    step(1, 1, 8'hEE, 0);
    step(0, 1, 8'h00, 0);
    do_reset();
    step(1, 1, 8'h5A, 0);
    step(0, 1, 8'h00, 0);

    // Reset mid-operation hides stale entries
    step(1, 0, 8'h77, 0); step(1, 0, 8'h78, 0);
    do_reset();
    step(0, 1, 8'h00, 0);

    // PC integration
    do_reset();
    step(1, 0, 8'hAA, 0);
    step(0, 1, 8'h00, 0);
    step(0, 0, 8'h00, 0);
    step(0, 0, 8'h00, 0);

    // Random traffic, alternating push-heavy and pop-heavy phases
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      pc_pct = ((i / 40) % 2 == 0) ? 70 : 30;
      step(1'($urandom_range(0, 99) < pc_pct),
           1'($urandom_range(0, 99) < 100 - pc_pct),
           8'($urandom_range(0, 255)),
           1'($urandom_range(0, 9) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
